a2_deser: RTL and testbench

- Serial-to-parallel stage directly downstream of the A2 serializer.
- Consumes the MSB-first bit stream framed by a serial valid strobe and rebuilds each frame into a left-aligned WIDTH-bit word plus its bit count.
- Presents each word through a single-entry valid/ready output register.
- Flags frames that are too short, and frames lost to back-pressure.

---
 rtl/a2_deser.sv | 144 ++++++++++++++
 tb/tb_a2_deser.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2_deser.sv
// Serial-to-parallel deserializer: rebuilds MSB-first framed bit streams into left-aligned words.
// Latency 1 cycle after frame end; single-entry valid/ready output register, frames dropped (overflow_o) when full.
// Backpressure: deser_ready_i only frees the output register; the serial side is never stalled.
module a2_deser #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = $clog2(WIDTH+1),
    parameter int MIN_BITS = 3
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             ser_data_val_i,
    input  logic             ser_data_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [CNT_W-1:0] deser_data_mod_o,
    output logic             deser_data_val_o,
    input  logic             deser_ready_i,
    output logic             short_frame_o,
    output logic             overflow_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_BITS);
    localparam logic [WIDTH-1:0] MSB_ONE  = WIDTH'(1) << (WIDTH-1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_dat_q, out_dat_d;
    logic [CNT_W-1:0]   out_mod_q, out_mod_d;
    logic               out_val_q, out_val_d;
    logic               short_q, short_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   base_shift;
    logic [CNT_W-1:0]   base_cnt;
    logic [WIDTH-1:0]   bit_mask;
    logic               frm_done;
    logic [WIDTH-1:0]   frm_dat;
    logic [CNT_W-1:0]   frm_cnt;
    logic               out_free;

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ser_data_val_i && !frm_done) state_d = S_SHIFT;
            S_SHIFT: if (!ser_data_val_i || frm_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: shift/count update and frame completion.
    // A new frame starts from an all-zero base, so unreceived LSBs read 0.
    always_comb begin
        base_shift = (state_q == S_SHIFT) ? shift_q : '0;
        base_cnt   = (state_q == S_SHIFT) ? cnt_q   : '0;
        bit_mask   = MSB_ONE >> base_cnt;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        frm_done   = 1'b0;
        frm_dat    = shift_q;
        frm_cnt    = cnt_q;
        if (ser_data_val_i) begin
            shift_d = ser_data_i ? (base_shift | bit_mask) : base_shift;
            cnt_d   = base_cnt + CNT_W'(1);
            if (base_cnt == LAST_CNT) begin
                frm_done = 1'b1;
                frm_dat  = shift_d;
                frm_cnt  = cnt_d;
                shift_d  = '0;
                cnt_d    = '0;
            end
        end else if (state_q == S_SHIFT) begin
            frm_done = 1'b1;
            shift_d  = '0;
            cnt_d    = '0;
        end
    end

    // Output register: free when empty or being consumed this cycle
    always_comb begin
        out_dat_d = out_dat_q;
        out_mod_d = out_mod_q;
        out_val_d = out_val_q;
        short_d   = 1'b0;
        ovf_d     = 1'b0;
        out_free  = !out_val_q || deser_ready_i;
        if (out_val_q && deser_ready_i) begin
            out_val_d = 1'b0;
        end
        if (frm_done) begin
            if (frm_cnt < MIN_CNT) begin
                short_d = 1'b1;
            end else if (out_free) begin
                out_dat_d = frm_dat;
                out_mod_d = frm_cnt;
                out_val_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            out_dat_q <= '0;
            out_mod_q <= '0;
            out_val_q <= 1'b0;
            short_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            out_dat_q <= out_dat_d;
            out_mod_q <= out_mod_d;
            out_val_q <= out_val_d;
            short_q   <= short_d;
            ovf_q     <= ovf_d;
        end
    end

    assign deser_data_o     = out_dat_q;
    assign deser_data_mod_o = out_mod_q;
    assign deser_data_val_o = out_val_q;
    assign short_frame_o    = short_q;
    assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_a2_deser.sv
// Bench for a2_deser: directed scenarios plus randomized traffic against a frame-level reference model.
module tb_a2_deser;

    localparam int WIDTH    = 8;
    localparam int CNT_W    = 4;
    localparam int MIN_BITS = 3;

    logic             clk_i = 1'b0;
    logic             arst_n_i = 1'b0;
    logic             ser_data_val_i = 1'b0;
    logic             ser_data_i = 1'b0;
    logic [WIDTH-1:0] deser_data_o;
    logic [CNT_W-1:0] deser_data_mod_o;
    logic             deser_data_val_o;
    logic             deser_ready_i = 1'b0;
    logic             short_frame_o;
    logic             overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] acc_q[$];
    int short_cnt  = 0;
    int ovf_cnt    = 0;
    int val_hi_cnt = 0;

    a2_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MIN_BITS(MIN_BITS)) dut (
        .clk_i            (clk_i),
        .arst_n_i         (arst_n_i),
        .ser_data_val_i   (ser_data_val_i),
        .ser_data_i       (ser_data_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .deser_ready_i    (deser_ready_i),
        .short_frame_o    (short_frame_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: collects frame bits in a queue, builds the word arithmetically on completion
    bit               m_bits[$];
    logic             m_val   = 1'b0;
    logic [WIDTH-1:0] m_dat   = '0;
    logic [CNT_W-1:0] m_mod   = '0;
    logic             m_short = 1'b0;
    logic             m_ovf   = 1'b0;

    always @(posedge clk_i or negedge arst_n_i) begin
        bit   done;
        bit   was_free;
        int   n;
        logic [WIDTH-1:0] w;
        if (!arst_n_i) begin
            m_bits.delete();
            m_val = 0; m_dat = '0; m_mod = '0; m_short = 0; m_ovf = 0;
        end else begin
            done = 0;
            m_short = 0;
            m_ovf = 0;
            was_free = !m_val || deser_ready_i;
            if (ser_data_val_i) begin
                m_bits.push_back(ser_data_i);
                if (m_bits.size() == WIDTH) done = 1;
            end else if (m_bits.size() > 0) begin
                done = 1;
            end
            if (m_val && deser_ready_i) m_val = 0;
            if (done) begin
                n = m_bits.size();
                w = '0;
                for (int i = 0; i < n; i++)
                    if (m_bits[i]) w = w + WIDTH'(1 << (WIDTH-1-i));
                m_bits.delete();
                if (n < MIN_BITS) m_short = 1;
                else if (was_free) begin
                    m_val = 1; m_dat = w; m_mod = CNT_W'(n);
                end else m_ovf = 1;
            end
        end
    end

    // Drive one cycle of inputs; log handshakes and pulses seen from the DUT
    task automatic step(input logic v, input logic d, input logic r);
        ser_data_val_i = v;
        ser_data_i     = d;
        deser_ready_i  = r;
        #1;
        if (deser_data_val_o && deser_ready_i)
            acc_q.push_back({deser_data_o, deser_data_mod_o});
        @(posedge clk_i);
        @(negedge clk_i);
        short_cnt += int'(short_frame_o);
        ovf_cnt   += int'(overflow_o);
        if (deser_data_val_o) val_hi_cnt++;
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] bits, input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b1, bits[WIDTH-1-i], r);
    endtask

    task automatic clear_logs();
        acc_q.delete();
        short_cnt = 0;
        ovf_cnt = 0;
        val_hi_cnt = 0;
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0;
        #2;
        n_checks++;
        if ({deser_data_o, deser_data_mod_o, deser_data_val_o, short_frame_o, overflow_o} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dat=%h mod=%0d val=%b sh=%b ov=%b, expected all 0",
                     deser_data_o, deser_data_mod_o, deser_data_val_o, short_frame_o, overflow_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (deser_data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_val: got %b expected 0", deser_data_val_o);
        end
    endtask

    task automatic test_basic();
        clear_logs();
        send_bits(8'b10110000, 5, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({deser_data_val_o, deser_data_o, deser_data_mod_o} !== {1'b1, 8'hB0, 4'd5}) begin
            n_fail++;
            $display("FAIL basic_word: got val=%b dat=%h mod=%0d expected val=1 dat=b0 mod=5",
                     deser_data_val_o, deser_data_o, deser_data_mod_o);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (val_hi_cnt != 1) begin
            n_fail++;
            $display("FAIL basic_val_cycles: got %0d expected 1", val_hi_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_bits(8'hA5, 8, 1'b1);
        send_bits(8'hE0, 3, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (acc_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words expected 2", acc_q.size());
        end else begin
            n_checks++;
            if (acc_q[0] !== {8'hA5, 4'd8}) begin
                n_fail++;
                $display("FAIL b2b_word0: got %h expected a58", acc_q[0]);
            end
            n_checks++;
            if (acc_q[1] !== {8'hE0, 4'd3}) begin
                n_fail++;
                $display("FAIL b2b_word1: got %h expected e03", acc_q[1]);
            end
        end
        n_checks++;
        if (short_cnt != 0 || ovf_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_pulses: got short=%0d ovf=%0d expected 0 0", short_cnt, ovf_cnt);
        end
    endtask

    task automatic test_short();
        clear_logs();
        send_bits(8'hC0, 2, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (short_cnt != 1) begin
            n_fail++;
            $display("FAIL short_pulse: got %0d pulses expected 1", short_cnt);
        end
        n_checks++;
        if (val_hi_cnt != 0) begin
            n_fail++;
            $display("FAIL short_val: got %0d valid cycles expected 0", val_hi_cnt);
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        send_bits(8'hF0, 4, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        send_bits(8'h80, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({deser_data_val_o, deser_data_o, deser_data_mod_o} !== {1'b1, 8'hF0, 4'd4}) begin
            n_fail++;
            $display("FAIL ovf_held: got val=%b dat=%h mod=%0d expected val=1 dat=f0 mod=4",
                     deser_data_val_o, deser_data_o, deser_data_mod_o);
        end
        n_checks++;
        if (ovf_cnt != 1 || short_cnt != 0) begin
            n_fail++;
            $display("FAIL ovf_pulse: got ovf=%0d short=%0d expected 1 0", ovf_cnt, short_cnt);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (acc_q.size() != 1 || acc_q[0] !== {8'hF0, 4'd4} || deser_data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_accept: got n=%0d val=%b expected one f04 and val=0",
                     acc_q.size(), deser_data_val_o);
        end
    endtask

    task automatic test_accept_and_load();
        clear_logs();
        send_bits(8'hE0, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        send_bits(8'hA0, 3, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({deser_data_val_o, deser_data_o, deser_data_mod_o} !== {1'b1, 8'hA0, 4'd3}) begin
            n_fail++;
            $display("FAIL accload_word: got val=%b dat=%h mod=%0d expected val=1 dat=a0 mod=3",
                     deser_data_val_o, deser_data_o, deser_data_mod_o);
        end
        n_checks++;
        if (ovf_cnt != 0 || acc_q.size() != 1) begin
            n_fail++;
            $display("FAIL accload_ovf: got ovf=%0d accepted=%0d expected 0 1", ovf_cnt, acc_q.size());
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        clear_logs();
        send_bits(8'hF0, 4, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        send_bits(8'hCC, 4, 1'b0);
        #2;
        arst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({deser_data_o, deser_data_mod_o, deser_data_val_o} !== 13'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got dat=%h mod=%0d val=%b expected 0",
                     deser_data_o, deser_data_mod_o, deser_data_val_o);
        end
        @(negedge clk_i);
        arst_n_i = 1'b1;
        send_bits(8'hCC, 6, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({deser_data_val_o, deser_data_o, deser_data_mod_o} !== {1'b1, 8'hCC, 4'd6}) begin
            n_fail++;
            $display("FAIL midreset_word: got val=%b dat=%h mod=%0d expected val=1 dat=cc mod=6",
                     deser_data_val_o, deser_data_o, deser_data_mod_o);
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 99) < 82) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0);
            n_checks++;
            if (deser_data_val_o !== m_val) begin
                n_fail++;
                $display("FAIL rnd_val cyc %0d: got %b expected %b", c, deser_data_val_o, m_val);
            end
            n_checks++;
            if (m_val && {deser_data_o, deser_data_mod_o} !== {m_dat, m_mod}) begin
                n_fail++;
                $display("FAIL rnd_word cyc %0d: got %h/%0d expected %h/%0d",
                         c, deser_data_o, deser_data_mod_o, m_dat, m_mod);
            end
            n_checks++;
            if ({short_frame_o, overflow_o} !== {m_short, m_ovf}) begin
                n_fail++;
                $display("FAIL rnd_pulses cyc %0d: got sh=%b ov=%b expected sh=%b ov=%b",
                         c, short_frame_o, overflow_o, m_short, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_short();
        test_overflow();
        test_accept_and_load();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
